// File: rtl/gray_pkg.sv
// Shared constants, FSM state type and saturation helpers for the gray packer.
package gray_pkg;

    localparam int PIX_W     = 8;
    localparam int GRAY_IN_W = 9;
    localparam int WORD_W    = 32;

    localparam logic [PIX_W-1:0] GRAY_MAX = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        PACK = 1'b1
    } state_t;

    // True when the converter result does not fit in an 8-bit pixel.
    function automatic logic gray_over(input logic [GRAY_IN_W-1:0] x);
        return (x > {1'b0, GRAY_MAX});
    endfunction

    // Clamp a 9-bit converter result to the 8-bit pixel range.
    function automatic logic [PIX_W-1:0] sat8(input logic [GRAY_IN_W-1:0] x);
        if (gray_over(x)) begin
            return GRAY_MAX;
        end
        return x[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/gray_out_reg.sv
// Single-entry valid/ready output register carrying a packed word, its lane
// enables and the end-of-frame flag. Contents are frozen while stalled.
module gray_out_reg #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [KEEP_W-1:0] keep,
    output logic              last,
    output logic              stall
);

    // A held word that the consumer is refusing blocks any new load.
    assign stall = valid && !ready;

    // Load a new word when empty or draining; otherwise drop valid on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            keep  <= '0;
            last  <= 1'b0;
        end else if (load && !stall) begin
            valid <= 1'b1;
            data  <= load_data;
            keep  <= load_keep;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gray_packer.sv
// Saturates 9-bit gray pixels to 8 bits and packs four per 32-bit output
// word, flushing a partial final word with keep bits and marking frame end.
module gray_packer
    import gray_pkg::*;
#(
    parameter int PIX_PER_WORD = 4,
    parameter int CNT_W        = 16
) (
    input  logic                    s00_axi_aclk,
    input  logic                    s00_axi_aresetn,
    input  logic [CNT_W-1:0]        frame_len,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    input  logic [GRAY_IN_W-1:0]    pix_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W-1:0]       out_data,
    output logic [PIX_PER_WORD-1:0] out_keep,
    output logic                    out_last,
    output logic                    frame_done,
    output logic                    sat_seen
);

    localparam int LANE_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    state_t                  state;
    logic [CNT_W-1:0]        len_q;
    logic [CNT_W-1:0]        pix_cnt;
    logic [CNT_W-1:0]        next_cnt;
    logic [LANE_W-1:0]       lane_cnt;
    logic [WORD_W-1:0]       pack_q;
    logic [WORD_W-1:0]       word;
    logic [PIX_PER_WORD-1:0] word_keep;
    logic [PIX_W-1:0]        pix_sat;
    logic                    pix_acc;
    logic                    lane_full;
    logic                    frame_end;
    logic                    word_done;
    logic                    stall;

    // Pixels are only taken while packing and while the output is not blocked.
    assign pix_ready = (state == PACK) && !stall;
    assign pix_acc   = pix_valid && pix_ready;
    assign pix_sat   = sat8(pix_data);
    assign next_cnt  = pix_cnt + CNT_W'(1);
    assign lane_full = (lane_cnt == LANE_W'(PIX_PER_WORD - 1));
    assign frame_end = (next_cnt == len_q);
    assign word_done = pix_acc && (lane_full || frame_end);

    // Merge the incoming pixel into its lane; lanes above it stay zero.
    always_comb begin
        word      = pack_q;
        word_keep = '0;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            if (LANE_W'(i) == lane_cnt) begin
                word[i*PIX_W +: PIX_W] = pix_sat;
            end
            word_keep[i] = (LANE_W'(i) <= lane_cnt);
        end
    end

    // Frame FSM: latch the length on entry, fill lanes, return to IDLE at frame end.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state    <= IDLE;
            len_q    <= '0;
            pix_cnt  <= '0;
            lane_cnt <= '0;
            pack_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((frame_len != '0) && !stall) begin
                        len_q    <= frame_len;
                        pix_cnt  <= '0;
                        lane_cnt <= '0;
                        pack_q   <= '0;
                        state    <= PACK;
                    end
                end
                PACK: begin
                    if (pix_acc) begin
                        pix_cnt <= next_cnt;
                        if (word_done) begin
                            lane_cnt <= '0;
                            pack_q   <= '0;
                        end else begin
                            lane_cnt <= lane_cnt + LANE_W'(1);
                            pack_q   <= word;
                        end
                        if (frame_end) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky saturation flag and the end-of-frame pulse after the last word drains.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            sat_seen   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sat_seen   <= sat_seen || (pix_acc && gray_over(pix_data));
            frame_done <= out_valid && out_ready && out_last;
        end
    end

    gray_out_reg #(
        .DATA_W (WORD_W),
        .KEEP_W (PIX_PER_WORD)
    ) u_out_reg (
        .clk       (s00_axi_aclk),
        .rst_n     (s00_axi_aresetn),
        .load      (word_done),
        .load_data (word),
        .load_keep (word_keep),
        .load_last (frame_end),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (out_data),
        .keep      (out_keep),
        .last      (out_last),
        .stall     (stall)
    );

endmodule
